// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add arbiter.
// Holds the FSM state encoding, requester IDs and a width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Ceiling log2, used to size the bit counter.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_add_arbiter_fa_cell.sv
// Combinational 1-bit full adder; the single shared arithmetic cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin front end for a bit-serial (LSB first) adder.
// Optional output o_Ovf (signed overflow) is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_arbiter
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic [1:0]       i_Req,
  input  logic [WIDTH-1:0] i_A0,
  input  logic [WIDTH-1:0] i_B0,
  input  logic             i_Cin0,
  input  logic [WIDTH-1:0] i_A1,
  input  logic [WIDTH-1:0] i_B1,
  input  logic             i_Cin1,
  output logic [1:0]       o_Gnt,
  output logic             o_Busy,
  output logic             o_Valid,
  output logic             o_Id,
  output logic [WIDTH-1:0] o_Sum,
  output logic             o_Cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             o_Ovf,
`endif
  output logic [1:0]       o_Dbg_State
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: a requester holds i_Req[r] and its operands until it sees
  // o_Gnt[r]; results are valid only in the single cycle o_Valid is high.
  state_e           r_state;
  logic             r_ptr;
  logic             r_owner;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_gnt;
  logic             r_valid;
  logic             r_id;
  logic [WIDTH-1:0] r_sum_out;
  logic             r_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             r_cmsb;
  logic             r_ovf;
`endif

  logic w_win;
  logic w_fa_sum;
  logic w_fa_cout;

  // Lone requester wins outright; a tie goes to the one not granted last.
  assign w_win = (i_Req == 2'b11) ? ~r_ptr : i_Req[1];

  fa_cell u_fa_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= REQ1;
      r_owner   <= REQ0;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_valid   <= 1'b0;
      r_id      <= 1'b0;
      r_sum_out <= '0;
      r_cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      r_cmsb    <= 1'b0;
      r_ovf     <= 1'b0;
`endif
    end else begin
      r_gnt   <= '0;
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|i_Req) begin
            r_a     <= w_win ? i_A1 : i_A0;
            r_b     <= w_win ? i_B1 : i_B0;
            r_carry <= w_win ? i_Cin1 : i_Cin0;
            r_owner <= w_win;
            r_ptr   <= w_win;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_gnt   <= w_win ? 2'b10 : 2'b01;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
          r_carry <= w_fa_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
`ifdef SERIAL_ADD_OVF_EN
            r_cmsb  <= r_carry;
`endif
            r_state <= DONE;
          end
        end
        DONE: begin
          r_valid   <= 1'b1;
          r_sum_out <= r_sum;
          r_cout    <= r_carry;
          r_id      <= r_owner;
`ifdef SERIAL_ADD_OVF_EN
          r_ovf     <= r_cmsb ^ r_carry;
`endif
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_Gnt       = r_gnt;
  assign o_Busy      = (r_state != IDLE);
  assign o_Valid     = r_valid;
  assign o_Id        = r_id;
  assign o_Sum       = r_sum_out;
  assign o_Cout      = r_cout;
`ifdef SERIAL_ADD_OVF_EN
  assign o_Ovf       = r_ovf;
`endif
  assign o_Dbg_State = r_state;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Scoreboard bench for serial_add_arbiter (WIDTH=8); define SERIAL_ADD_OVF_EN
// on both DUT and bench to exercise the overflow output.
module tb_serial_add_arbiter;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic         c0, c1;
  logic [1:0]   o_gnt;
  logic         o_busy, o_valid, o_id, o_cout, ovf_obs;
  logic [W-1:0] o_sum;
  logic [1:0]   dbg_state;
`ifdef SERIAL_ADD_OVF_EN
  logic         o_ovf;
  assign ovf_obs = o_ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  serial_add_arbiter #(.WIDTH(W)) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_Req       (req),
    .i_A0        (a0),
    .i_B0        (b0),
    .i_Cin0      (c0),
    .i_A1        (a1),
    .i_B1        (b1),
    .i_Cin1      (c1),
    .o_Gnt       (o_gnt),
    .o_Busy      (o_busy),
    .o_Valid     (o_valid),
    .o_Id        (o_id),
    .o_Sum       (o_sum),
    .o_Cout      (o_cout),
`ifdef SERIAL_ADD_OVF_EN
    .o_Ovf       (o_ovf),
`endif
    .o_Dbg_State (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W+2:0] exp_q[$];   // {ovf, id, cout, sum}
  logic [1:0]   gnt_q[$];
  int           lat_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic         ptr = 1'b1;
  logic         space_chk = 1'b0;
  int           last_valid = -1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W+2:0] model(input logic id, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic c);
    logic [W:0]   full;
    logic [W-1:0] low;
    logic         ovf;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
`ifdef SERIAL_ADD_OVF_EN
    low = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, c};
    ovf = low[W-1] ^ full[W];
`else
    low = '0;
    ovf = 1'b0;
`endif
    return {ovf, id, full[W], full[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_txn(input logic [1:0] r);
    logic w;
    w = (r == 2'b11) ? ~ptr : r[1];
    ptr = w;
    gnt_q.push_back(w ? 2'b10 : 2'b01);
    exp_q.push_back(w ? model(1'b1, a1, b1, c1) : model(1'b0, a0, b0, c0));
  endtask

  task automatic drive(input logic [1:0] r, input logic [W-1:0] xa0, input logic [W-1:0] xb0,
                       input logic xc0, input logic [W-1:0] xa1, input logic [W-1:0] xb1,
                       input logic xc1);
    a0 = xa0; b0 = xb0; c0 = xc0;
    a1 = xa1; b1 = xb1; c1 = xc1;
    req = r;
    push_txn(r);
  endtask

  task automatic wait_gnt(input int budget);
    int i;
    i = 0;
    while (gnt_q.size() != 0 && i < budget) begin
      @(negedge clk); #2;
      i++;
    end
    if (gnt_q.size() != 0) begin
      check("gnt_timeout", 64'(gnt_q.size()), 64'd0);
      gnt_q.delete();
    end
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk); #2;
      i++;
    end
    if (exp_q.size() != 0) begin
      check("valid_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge clk); #2;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (o_gnt != 2'b00) begin
        if (gnt_q.size() == 0) check("gnt_unexpected", 64'(o_gnt), 64'd0);
        else begin
          check("gnt", 64'(o_gnt), 64'(gnt_q.pop_front()));
          check("busy_run", 64'(o_busy), 64'd1);
          check("state_run", 64'(dbg_state), 64'd1);
          lat_q.push_back(cyc);
        end
      end
      if (o_valid) begin
        if (exp_q.size() == 0) check("valid_unexpected", 64'd1, 64'd0);
        else begin
          check("result", 64'({ovf_obs, o_id, o_cout, o_sum}), 64'(exp_q.pop_front()));
          check("busy_done", 64'(o_busy), 64'd0);
          if (lat_q.size() != 0) check("latency", 64'(cyc - lat_q.pop_front()), 64'd9);
          if (space_chk && last_valid >= 0) check("spacing", 64'(cyc - last_valid), 64'd10);
          last_valid = cyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    req = 2'b00;
    a0 = '0; b0 = '0; c0 = 1'b0;
    a1 = '0; b1 = '0; c1 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", 64'(o_gnt), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_out", 64'({ovf_obs, o_id, o_cout, o_sum}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;

    // single request, then hold check
    @(negedge clk); #2;
    drive(2'b01, 8'h3C, 8'h05, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_gnt(5);
    req = 2'b00;
    wait_idle(30);
    repeat (3) @(negedge clk);
    #2;
    check("sum_hold", 64'(o_sum), 64'h41);

    // carry-in and carry-out through requester 1
    drive(2'b10, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b1);
    wait_gnt(5);
    req = 2'b00;
    wait_idle(30);

    // both held: must alternate 0,1,0,1 at 10-cycle spacing
    a0 = 8'h11; b0 = 8'h22; c0 = 1'b1;
    a1 = 8'hF0; b1 = 8'h20; c1 = 1'b0;
    for (int i = 0; i < 4; i++) push_txn(2'b11);
    space_chk = 1'b1;
    last_valid = -1;
    req = 2'b11;
    wait_gnt(60);
    req = 2'b00;
    wait_idle(40);
    space_chk = 1'b0;

    // operands change after capture
    drive(2'b01, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_gnt(5);
    req = 2'b00;
    a0 = 8'h00; b0 = 8'hFF; c0 = 1'b1;
    wait_idle(30);

    // random single and tied requests
    for (int i = 0; i < 8; i++) begin
      drive(2'($urandom_range(1, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)));
      wait_gnt(5);
      req = 2'b00;
      a0 = 8'($urandom_range(0, 255));
      a1 = 8'($urandom_range(0, 255));
      wait_idle(30);
    end

    // reset in the middle of RUN aborts the transaction
    drive(2'b10, 8'h00, 8'h00, 1'b0, 8'h55, 8'hAA, 1'b1);
    wait_gnt(5);
    req = 2'b00;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_gnt", 64'(o_gnt), 64'd0);
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_valid", 64'(o_valid), 64'd0);
    check("abort_out", 64'({ovf_obs, o_id, o_cout, o_sum}), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    exp_q.delete();
    lat_q.delete();
    ptr = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #2;
    drive(2'b11, 8'h01, 8'h02, 1'b0, 8'h03, 8'h04, 1'b0);
    wait_gnt(5);
    req = 2'b00;
    wait_idle(30);

`ifdef SERIAL_ADD_OVF_EN
    drive(2'b01, 8'h7F, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_gnt(5);
    req = 2'b00;
    wait_idle(30);
    drive(2'b01, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_gnt(5);
    req = 2'b00;
    wait_idle(30);
`endif

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
